// File: rtl/gol_gen_engine.sv
// gol_gen_engine: one Game-of-Life (B3/S23) generation from a source RAM into a destination RAM.
// Define GOL_WRAP_EN for a toroidal grid; otherwise out-of-grid neighbours count as dead.
module gol_gen_engine #(
  parameter int XW = 8,
  parameter int YW = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic [15:0]        gen_count_o,
  output logic [XW+YW-1:0]   src_addr_o,
  input  logic [3:0]         src_dout_i,
  output logic [XW+YW-1:0]   dst_addr_o,
  output logic               dst_we_o,
  output logic [3:0]         dst_din_o
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_e;
  state_e            state_q;
  logic [XW-1:0]     x_q, nx;
  logic [YW-1:0]     y_q, ny;
  logic [3:0]        k_q, cnt_q, self_q, n;
  logic [XW+YW-1:0]  src_addr_q;
  logic [15:0]       gen_q;
  logic [2:0]        age1;
  logic              edge_ok, live_in;

  // {left, right, up, down} for read k in the fixed neighbour order
  function automatic logic [3:0] dirs(input logic [3:0] k);
    return {k == 4'd1 || k == 4'd4 || k == 4'd6, k == 4'd3 || k == 4'd5 || k == 4'd8,
            k >= 4'd1 && k <= 4'd3, k >= 4'd6 && k <= 4'd8};
  endfunction

  function automatic logic [XW+YW-1:0] naddr(input logic [3:0] k, input logic [XW-1:0] x,
                                             input logic [YW-1:0] y);
    logic [3:0] d;
    d = dirs(k);
    return {d[1] ? y - 1'b1 : d[0] ? y + 1'b1 : y, d[3] ? x - 1'b1 : d[2] ? x + 1'b1 : x};
  endfunction

`ifdef GOL_WRAP_EN
  assign edge_ok = 1'b1;
`else
  logic [3:0] dj;
  // src_dout carries read k-1 during RD k, and read 8 during WR
  assign dj = dirs(state_q == WR ? 4'd8 : k_q - 4'd1);
  assign edge_ok = !(dj[3] && x_q == '0) && !(dj[2] && &x_q) &&
                   !(dj[1] && y_q == '0) && !(dj[0] && &y_q);
`endif

  always_comb begin
    live_in   = src_dout_i[0] & edge_ok;
    n         = cnt_q + {3'b0, live_in};
    age1      = self_q[3:1] == 3'd7 ? 3'd7 : self_q[3:1] + 3'd1;
    nx        = x_q + 1'b1;
    ny        = &x_q ? y_q + 1'b1 : y_q;
    dst_din_o = state_q != WR ? 4'h0 :
                self_q[0] && (n == 4'd2 || n == 4'd3) ? {age1, 1'b1} :
                !self_q[0] && n == 4'd3 ? 4'h1 : 4'h0;
  end

  assign busy_o      = state_q == RD || state_q == WR;
  assign done_o      = state_q == DONE;
  assign dst_we_o    = state_q == WR;
  assign dst_addr_o  = {y_q, x_q};
  assign src_addr_o  = src_addr_q;
  assign gen_count_o = gen_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      self_q     <= '0;
      src_addr_q <= '0;
      gen_q      <= '0;
    end else begin
      case (state_q)
        IDLE: if (start_i) begin
          state_q    <= RD;
          x_q        <= '0;
          y_q        <= '0;
          k_q        <= '0;
          cnt_q      <= '0;
          src_addr_q <= '0;
        end
        RD: begin
          if (k_q == 4'd1) self_q <= src_dout_i;
          else if (k_q != 4'd0) cnt_q <= n;
          if (k_q == 4'd8) state_q <= WR;
          else begin
            k_q        <= k_q + 4'd1;
            src_addr_q <= naddr(k_q + 4'd1, x_q, y_q);
          end
        end
        WR: if (&x_q && &y_q) begin
          state_q <= DONE;
          gen_q   <= gen_q + 16'd1;
        end else begin
          state_q    <= RD;
          k_q        <= '0;
          cnt_q      <= '0;
          x_q        <= nx;
          y_q        <= ny;
          src_addr_q <= {ny, nx};
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gol_gen_engine.sv
// tb_gol_gen_engine: 16x16 grid bench with behavioural source/destination RAMs and a per-write scoreboard.
module tb_gol_gen_engine;
  localparam int XW = 4, YW = 4, N = 256;
  logic clk = 1'b0, rst_n = 1'b0, start_i = 1'b0;
  logic busy_o, done_o, dst_we_o;
  logic [15:0] gen_count_o;
  logic [7:0] src_addr_o, dst_addr_o;
  logic [3:0] src_dout_i = 4'h0, dst_din_o;
  logic [3:0] src_mem [N];
  logic [3:0] dst_mem [N];
  logic [11:0] exp_q [$];
  int n_cmp = 0, n_bad = 0;

  gol_gen_engine #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
    .gen_count_o(gen_count_o), .src_addr_o(src_addr_o), .src_dout_i(src_dout_i),
    .dst_addr_o(dst_addr_o), .dst_we_o(dst_we_o), .dst_din_o(dst_din_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    src_dout_i <= src_mem[src_addr_o];
    if (dst_we_o) dst_mem[dst_addr_o] <= dst_din_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && dst_we_o) begin
      if (exp_q.size() == 0) check("sb_extra_write", {dst_addr_o, dst_din_o}, 12'hFFF);
      else check("sb_cell", {dst_addr_o, dst_din_o}, exp_q.pop_front());
    end
  end

  function automatic logic [3:0] model(input int x, input int y);
    int n = 0, px, py;
    logic [3:0] s = src_mem[y * 16 + x];
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        if (dx == 0 && dy == 0) continue;
        px = x + dx;
        py = y + dy;
`ifdef GOL_WRAP_EN
        px = (px + 16) % 16;
        py = (py + 16) % 16;
`else
        if (px < 0 || px > 15 || py < 0 || py > 15) continue;
`endif
        n += int'(src_mem[py * 16 + px][0]);
      end
    if (s[0] && (n == 2 || n == 3)) return {(s[3:1] == 3'd7) ? 3'd7 : s[3:1] + 3'd1, 1'b1};
    return (!s[0] && n == 3) ? 4'h1 : 4'h0;
  endfunction

  function automatic int live_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(dst_mem[i][0]);
    return c;
  endfunction

  task automatic clear_src();
    for (int i = 0; i < N; i++) src_mem[i] = 4'h0;
  endtask

  task automatic push_exp();
    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) exp_q.push_back({8'(y * 16 + x), model(x, y)});
  endtask

  task automatic wait_done();
    int i = 0;
    while (!done_o && i < 3000) begin
      @(negedge clk);
      i++;
    end
    check("done_seen", done_o, 1'b1);
  endtask

  task automatic gen();
    push_exp();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done();
    check("sb_drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] nb;
    logic [3:0] self_v;
    logic [3:0] exp;
  } vec_t;

  initial begin
    vec_t tv [9];
    int odx [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int ody [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
    logic [15:0] gc0;
    int e_busy, e_done, e_we;
    tv[0] = '{8'b0000_0111, 4'h0, 4'h1};
    tv[1] = '{8'b0001_0001, 4'h6, 4'h0};
    tv[2] = '{8'b1000_0001, 4'h1, 4'h3};
    tv[3] = '{8'b1010_1000, 4'hD, 4'hF};
    tv[4] = '{8'b0100_0010, 4'hF, 4'hF};
    tv[5] = '{8'b0011_1100, 4'h1, 4'h0};
    tv[6] = '{8'b0000_0001, 4'h1, 4'h0};
    tv[7] = '{8'b1111_1111, 4'h0, 4'h0};
    tv[8] = '{8'b1100_0001, 4'hE, 4'h1};
    clear_src();
    for (int i = 0; i < N; i++) dst_mem[i] = 4'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_we", dst_we_o, 1'b0);
    check("rst_gen", gen_count_o, 16'h0);
    check("rst_src_addr", src_addr_o, 8'h0);
    check("rst_dst_addr", dst_addr_o, 8'h0);
    check("rst_dst_din", dst_din_o, 4'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    // 2x2 block ages to saturation over 8 generations
    src_mem[8'h55] = 4'h1; src_mem[8'h56] = 4'h1; src_mem[8'h65] = 4'h1; src_mem[8'h66] = 4'h1;
    for (int g = 0; g < 8; g++) begin
      gen();
      for (int i = 0; i < N; i++) src_mem[i] = dst_mem[i];
    end
    check("block_55", dst_mem[8'h55], 4'hF);
    check("block_56", dst_mem[8'h56], 4'hF);
    check("block_65", dst_mem[8'h65], 4'hF);
    check("block_66", dst_mem[8'h66], 4'hF);
    check("block_live", live_count(), 4);
    check("block_gen", gen_count_o, 16'd8);
    clear_src();
    src_mem[8'h9A] = 4'h1; src_mem[8'hAA] = 4'h1; src_mem[8'hBA] = 4'h1;
    gen();
    check("blink_A9", dst_mem[8'hA9], 4'h1);
    check("blink_AA", dst_mem[8'hAA], 4'h3);
    check("blink_AB", dst_mem[8'hAB], 4'h1);
    check("blink_live", live_count(), 3);
    clear_src();
    src_mem[8'h5F] = 4'h1; src_mem[8'h50] = 4'h1; src_mem[8'h51] = 4'h1;
    gen();
`ifdef GOL_WRAP_EN
    check("wrap_40", dst_mem[8'h40], 4'h1);
    check("wrap_50", dst_mem[8'h50], 4'h3);
    check("wrap_60", dst_mem[8'h60], 4'h1);
    check("wrap_live", live_count(), 3);
`else
    check("edge_live", live_count(), 0);
`endif
    for (int i = 0; i < 9; i++) begin
      clear_src();
      src_mem[8'h77] = tv[i].self_v;
      for (int k = 0; k < 8; k++)
        if (tv[i].nb[k]) src_mem[(7 + ody[k]) * 16 + 7 + odx[k]] = 4'hB;
      gen();
      check($sformatf("vec%0d_cell77", i), dst_mem[8'h77], tv[i].exp);
    end
    // exact frame timing on an empty grid, with ignored starts mid-frame and at DONE
    clear_src();
    gc0 = gen_count_o;
    e_busy = 0; e_done = 0; e_we = 0;
    push_exp();
    start_i = 1'b1;
    for (int c = 1; c <= 2565; c++) begin
      @(negedge clk);
      if (busy_o !== (c <= 2560)) e_busy++;
      if (done_o !== (c == 2561)) e_done++;
      if (dst_we_o !== (c <= 2560 && c % 10 == 0)) e_we++;
      start_i = (c == 50 || c == 2561);
    end
    start_i = 1'b0;
    check("busy_timing", e_busy, 0);
    check("done_timing", e_done, 0);
    check("we_timing", e_we, 0);
    check("gen_once", gen_count_o, 16'(gc0 + 16'd1));
    check("timing_drain", exp_q.size(), 0);
    // asynchronous reset mid-frame
    src_mem[8'h9A] = 4'h1; src_mem[8'hAA] = 4'h1; src_mem[8'hBA] = 4'h1;
    push_exp();
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (999) @(negedge clk);
    check("pre_rst_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 1'b0);
    check("mid_rst_we", dst_we_o, 1'b0);
    check("mid_rst_gen", gen_count_o, 16'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_idle", busy_o, 1'b0);
    gen();
    check("post_rst_gen", gen_count_o, 16'd1);
    check("post_rst_AA", dst_mem[8'hAA], 4'h3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
